// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains a FIFO read port: pops one word per frame and
// sends start, DATA_BITS data bits LSB first, optional parity, then stop bits.
module fifo_uart_tx #(
    parameter int DATA_BITS  = 8,
    parameter int BAUD_DIV   = 434,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_enable,
    input  logic                 i_fifo_empty,
    input  logic [DATA_BITS-1:0] i_fifo_data,
    output logic                 o_fifo_stb,
    output logic                 o_tx,
    output logic                 o_busy
);

    localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int CW = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = (STOP_BITS == 2);
    localparam logic          ODD       = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    state_e               state_q, state_d;
    logic [BW-1:0]        baud_q, baud_d;
    logic [CW-1:0]        bit_q, bit_d;
    logic                 stop_q, stop_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 stb_q, stb_d;
    logic                 busy_q, busy_d;

    logic                 start_ok;
    logic                 baud_tc;
    logic                 launch;
    logic [DATA_BITS-1:0] shift_nxt;

    assign start_ok  = i_enable && !i_fifo_empty;
    assign baud_tc   = (baud_q == BAUD_LAST);
    assign shift_nxt = shift_q >> 1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            stb_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            stb_q   <= stb_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        stb_d   = 1'b0;
        launch  = 1'b0;

        if (state_q != IDLE) begin
            baud_d = baud_tc ? '0 : baud_q + BW'(1);
        end

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (start_ok) begin
                    launch = 1'b1;
                end
            end
            START: begin
                if (baud_tc) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (baud_tc) begin
                    if (bit_q == BIT_LAST) begin
                        bit_d = '0;
                        if (PARITY_EN != 0) begin
                            state_d = PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                            stop_d  = 1'b0;
                        end
                    end else begin
                        shift_d = shift_nxt;
                        tx_d    = shift_nxt[0];
                        bit_d   = bit_q + CW'(1);
                    end
                end
            end
            PARITY: begin
                if (baud_tc) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                    stop_d  = 1'b0;
                end
            end
            STOP: begin
                if (baud_tc) begin
                    if (stop_q == STOP_LAST) begin
                        // Back-to-back frames chain here with no idle bit between them.
                        if (start_ok) begin
                            launch = 1'b1;
                        end else begin
                            state_d = IDLE;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        if (launch) begin
            shift_d = i_fifo_data;
            par_d   = (^i_fifo_data) ^ ODD;
            stb_d   = 1'b1;
            tx_d    = 1'b0;
            state_d = START;
            baud_d  = '0;
        end

        busy_d = (state_d != IDLE);
    end

    assign o_fifo_stb = stb_q;
    assign o_tx       = tx_q;
    assign o_busy     = busy_q;

endmodule
